mac_tx_framer: RTL and testbench

//  Ethernet TX framer between the ARP/L3 byte source and the RGMII TX adapter (its MAC_TXV/MAC_TXD).

---
 rtl/eth_pkg.sv | 29 ++
 rtl/mac_tx_framer_if.sv | 21 ++
 rtl/crc32_d8.sv | 20 ++
 rtl/mac_tx_framer.sv | 135 +++++++++++++
 tb/tb_mac_tx_framer.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet constants, framer state type and FCS byte selection helper.
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
  localparam logic [7:0]  ETH_SFD         = 8'hD5;
  localparam logic [31:0] CRC32_POLY_R    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE_R = 32'hDEBB20E3;
  localparam int          ETH_MIN_PAYLOAD = 60;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } framer_state_e;

  // Good frames send the complemented CRC; aborted frames send it raw so the FCS is wrong.
  function automatic logic [7:0] fcs_byte(input logic [31:0] crc, input logic bad,
                                          input logic [1:0] idx);
    logic [31:0] f;
    f = bad ? crc : ~crc;
    return f[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/mac_tx_framer_if.sv
// Payload valid/ready stream into the framer and the byte stream out to the RGMII TX adapter.
interface mac_tx_framer_if;

  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       mac_txv;
  logic [7:0] mac_txd;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, mac_txv, mac_txd
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, mac_txv, mac_txd
  );

endinterface

// File: rtl/crc32_d8.sv
// Combinational IEEE 802.3 CRC-32 step (reflected, LSB first) over one byte.
module crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  always_comb begin
    logic [31:0] c;
    c = crc_in;
    for (int unsigned i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CRC32_POLY_R;
      else                c = c >> 1;
    end
    crc_out = c;
  end

endmodule

// File: rtl/mac_tx_framer.sv
// Ethernet TX framer: preamble/SFD, payload, zero pad, CRC-32 FCS and inter-frame gap.
module mac_tx_framer
  import eth_pkg::*;
#(
  parameter int MIN_LEN = ETH_MIN_PAYLOAD,
  parameter int MAX_LEN = 1514,
  parameter int IFG_LEN = 12
) (
  input  logic           clk,
  input  logic           rstn,
  mac_tx_framer_if.slave bus,
  output logic           busy,
  output logic           frame_done,
  output logic           tx_err
);

  localparam logic [10:0] MIN_L = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L = 11'(MAX_LEN);
  // The IDLE cycle before the next preamble supplies the last idle cycle of the gap.
  localparam logic [10:0]   IFG_END  = (IFG_LEN > 1) ? 11'(IFG_LEN - 2) : '0;
  localparam framer_state_e POST_FCS = (IFG_LEN > 1) ? ST_IFG : ST_IDLE;

  framer_state_e state_q;
  logic [10:0]   cnt_q, byte_cnt_q, byte_cnt_inc, byte_cnt_d;
  logic [31:0]   crc_q, crc_d;
  logic [7:0]    crc_data, txd_q;
  logic          txv_q, bad_q, frame_done_q, tx_err_q;

  assign byte_cnt_inc = byte_cnt_q + 11'd1;
  assign byte_cnt_d   = (byte_cnt_q >= MAX_L) ? MAX_L : byte_cnt_inc;
  assign crc_data     = (state_q == ST_PAD) ? 8'h00 : bus.in_data;

  crc32_d8 u_crc (
    .crc_in  (crc_q),
    .data    (crc_data),
    .crc_out (crc_d)
  );

  // Each state registers the byte it emits, so mac_txd trails the state by one cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      byte_cnt_q   <= '0;
      crc_q        <= CRC32_INIT;
      bad_q        <= 1'b0;
      txv_q        <= 1'b0;
      txd_q        <= '0;
      frame_done_q <= 1'b0;
      tx_err_q     <= 1'b0;
    end else begin
      txv_q        <= 1'b0;
      txd_q        <= '0;
      frame_done_q <= 1'b0;
      tx_err_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            state_q    <= ST_PRE;
            cnt_q      <= '0;
            byte_cnt_q <= '0;
            bad_q      <= 1'b0;
          end
        end
        ST_PRE: begin
          txv_q <= 1'b1;
          txd_q <= ETH_PREAMBLE;
          cnt_q <= cnt_q + 11'd1;
          if (cnt_q == 11'd6) state_q <= ST_SFD;
        end
        ST_SFD: begin
          txv_q   <= 1'b1;
          txd_q   <= ETH_SFD;
          crc_q   <= CRC32_INIT;
          state_q <= ST_DATA;
        end
        ST_DATA: begin
          txv_q <= 1'b1;
          if (bus.in_valid) begin
            txd_q      <= bus.in_data;
            crc_q      <= crc_d;
            byte_cnt_q <= byte_cnt_d;
            cnt_q      <= '0;
            if (bus.in_last) begin
              state_q <= (byte_cnt_inc < MIN_L) ? ST_PAD : ST_FCS;
            end else if (byte_cnt_inc >= MAX_L) begin
              tx_err_q <= 1'b1;
              bad_q    <= 1'b1;
              state_q  <= ST_FCS;
            end
          end else begin
            // Underrun: first (bad) FCS byte goes out now to keep mac_txv contiguous.
            txd_q    <= fcs_byte(crc_q, 1'b1, 2'd0);
            tx_err_q <= 1'b1;
            bad_q    <= 1'b1;
            cnt_q    <= 11'd1;
            state_q  <= ST_FCS;
          end
        end
        ST_PAD: begin
          txv_q      <= 1'b1;
          crc_q      <= crc_d;
          byte_cnt_q <= byte_cnt_inc;
          if (byte_cnt_inc >= MIN_L) begin
            cnt_q   <= '0;
            state_q <= ST_FCS;
          end
        end
        ST_FCS: begin
          txv_q <= 1'b1;
          txd_q <= fcs_byte(crc_q, bad_q, cnt_q[1:0]);
          cnt_q <= cnt_q + 11'd1;
          if (cnt_q == 11'd3) begin
            frame_done_q <= 1'b1;
            cnt_q        <= '0;
            state_q      <= POST_FCS;
          end
        end
        ST_IFG: begin
          cnt_q <= cnt_q + 11'd1;
          if (cnt_q == IFG_END) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready = (state_q == ST_DATA);
  assign bus.mac_txv  = txv_q;
  assign bus.mac_txd  = txd_q;
  assign busy         = (state_q != ST_IDLE);
  assign frame_done   = frame_done_q;
  assign tx_err       = tx_err_q;

endmodule

// File: tb/tb_mac_tx_framer.sv
// Directed plus randomized bench for mac_tx_framer against a table-driven frame model.
module tb_mac_tx_framer;

  typedef logic [7:0] bq_t[$];
  localparam int LIM = 20000;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       drv_valid = 1'b0, drv_last = 1'b0, sel = 1'b0;
  logic [7:0] drv_data = 8'h00;
  logic       busy_a, fd_a, err_a, busy_b, fd_b, err_b;
  logic       sel_ready, sel_txv, sel_busy, sel_fd, sel_err;
  logic [7:0] sel_txd;

  int   n_checks = 0, n_err = 0;
  bq_t  cap_q, exp_q;
  int   gaps_q[$];
  int   fd_cnt = 0, err_cnt = 0, gap_ready = 0, idle_txd = 0, gap_len = 0;
  bit   seen = 0;
  logic [31:0] crc_tab [256];
  logic [7:0]  sp_q[$];
  logic        sl_q[$];

  always #5 clk = ~clk;

  mac_tx_framer_if ifa ();
  mac_tx_framer_if ifb ();

  assign ifa.in_valid = drv_valid & ~sel;
  assign ifa.in_data  = drv_data;
  assign ifa.in_last  = drv_last;
  assign ifb.in_valid = drv_valid & sel;
  assign ifb.in_data  = drv_data;
  assign ifb.in_last  = drv_last;

  assign sel_ready = sel ? ifb.in_ready : ifa.in_ready;
  assign sel_txv   = sel ? ifb.mac_txv  : ifa.mac_txv;
  assign sel_txd   = sel ? ifb.mac_txd  : ifa.mac_txd;
  assign sel_busy  = sel ? busy_b : busy_a;
  assign sel_fd    = sel ? fd_b   : fd_a;
  assign sel_err   = sel ? err_b  : err_a;

  mac_tx_framer #(.MIN_LEN(0), .MAX_LEN(64), .IFG_LEN(12)) dut_a (
    .clk(clk), .rstn(rstn), .bus(ifa), .busy(busy_a), .frame_done(fd_a), .tx_err(err_a)
  );

  mac_tx_framer #(.MIN_LEN(60), .MAX_LEN(1514), .IFG_LEN(12)) dut_b (
    .clk(clk), .rstn(rstn), .bus(ifb), .busy(busy_b), .frame_done(fd_b), .tx_err(err_b)
  );

  // Output monitor: captures txv bytes, idle gaps and pulse counts away from the clock edge.
  initial begin
    forever begin
      @(negedge clk);
      if (sel_txv) begin
        cap_q.push_back(sel_txd);
        if (seen && gap_len > 0) gaps_q.push_back(gap_len);
        gap_len = 0;
        seen = 1;
      end else begin
        if (seen) begin
          gap_len++;
          if (sel_ready) gap_ready++;
        end
        if (sel_txd != 8'h00) idle_txd++;
      end
      if (sel_fd)  fd_cnt++;
      if (sel_err) err_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_ne(input string tag, input logic [31:0] obs, input logic [31:0] bad);
    n_checks++;
    assert (obs !== bad) else begin
      n_err++;
      $error("FAIL %s: observed %h must differ from %h", tag, obs, bad);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    return crc_tab[c[7:0] ^ b] ^ (c >> 8);
  endfunction

  // Reference frame: preamble, SFD, payload, zero pad to min_len, FCS (raw CRC when bad).
  task automatic build_exp(input bq_t p, input int min_len, input bit bad);
    logic [31:0] c, f;
    c = 32'hFFFFFFFF;
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    foreach (p[i]) begin
      exp_q.push_back(p[i]);
      c = crc_upd(c, p[i]);
    end
    for (int i = p.size(); i < min_len; i++) begin
      exp_q.push_back(8'h00);
      c = crc_upd(c, 8'h00);
    end
    f = bad ? c : ~c;
    for (int k = 0; k < 4; k++) exp_q.push_back(f[8*k +: 8]);
  endtask

  function automatic bq_t rand_payload(input int n);
    bq_t p;
    for (int i = 0; i < n; i++) p.push_back(8'($urandom_range(255)));
    return p;
  endfunction

  task automatic queue_frame(input bq_t p);
    foreach (p[i]) begin
      sp_q.push_back(p[i]);
      sl_q.push_back(i == p.size() - 1);
    end
  endtask

  task automatic run_stream(input int stop_after, output int sent);
    int idx, guard, e0;
    bit xfer;
    idx = 0; guard = 0; e0 = err_cnt;
    drv_valid = 1'b1; drv_data = sp_q[0]; drv_last = sl_q[0];
    while (idx < sp_q.size() && guard < LIM) begin
      @(negedge clk);
      xfer = sel_ready & drv_valid;
      @(posedge clk); #1;
      guard++;
      if (xfer) begin
        idx++;
        if (idx < sp_q.size()) begin
          drv_data = sp_q[idx];
          drv_last = sl_q[idx];
        end
      end
      if (stop_after >= 0 && idx == stop_after) break;
      if (err_cnt != e0) break;
    end
    drv_valid = 1'b0; drv_last = 1'b0;
    if (guard >= LIM) chk("stream_timeout", guard, 0);
    sent = idx;
    sp_q.delete(); sl_q.delete();
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    do begin
      @(posedge clk); #1;
      g++;
    end while ((sel_busy || sel_txv) && g < LIM);
    if (g >= LIM) chk("idle_timeout", g, 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_stream(input string tag, input int base);
    int bad, first;
    bad = 0; first = -1;
    chk({tag, "_len"}, cap_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size() && base + i < cap_q.size(); i++)
      if (cap_q[base+i] !== exp_q[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    chk({tag, "_bytes_bad"}, bad, 0);
    if (first >= 0) chk({tag, "_first_bad"}, {24'd0, cap_q[base+first]}, {24'd0, exp_q[first]});
  endtask

  function automatic logic [31:0] residue(input int base);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = base + 8; i < cap_q.size(); i++) c = crc_upd(c, cap_q[i]);
    return c;
  endfunction

  initial begin
    bq_t p, p2;
    int  base, f0, e0, g0, gb, sent, len, min_len, g;
    logic [31:0] c;

    for (int i = 0; i < 256; i++) begin
      c = 32'(i);
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tab[i] = c;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("reset_a", {19'd0, ifa.mac_txv, ifa.mac_txd, ifa.in_ready, busy_a, fd_a, err_a}, 32'd0);
    chk("reset_b", {19'd0, ifb.mac_txv, ifb.mac_txd, ifb.in_ready, busy_b, fd_b, err_b}, 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Known-answer frame: "123456789", no padding.
    sel = 1'b0; base = cap_q.size(); f0 = fd_cnt; e0 = err_cnt;
    p.delete();
    for (int i = 0; i < 9; i++) p.push_back(8'(8'h31 + i));
    exp_q.delete();
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    foreach (p[i]) exp_q.push_back(p[i]);
    exp_q.push_back(8'h26); exp_q.push_back(8'h39); exp_q.push_back(8'hF4); exp_q.push_back(8'hCB);
    queue_frame(p);
    run_stream(-1, sent);
    wait_idle();
    check_stream("kat", base);
    chk("kat_frame_done", fd_cnt - f0, 1);
    chk("kat_tx_err", err_cnt - e0, 0);

    // ARP-sized frame padded to 60.
    sel = 1'b1; base = cap_q.size(); f0 = fd_cnt;
    p.delete();
    repeat (6) p.push_back(8'hFF);
    for (int i = 0; i < 6; i++) p.push_back(8'($urandom_range(255)));
    p.push_back(8'h08); p.push_back(8'h06);
    p = {p, rand_payload(28)};
    exp_q.delete();
    build_exp(p, 60, 1'b0);
    queue_frame(p);
    run_stream(-1, sent);
    wait_idle();
    check_stream("arp", base);
    chk("arp_residue", residue(base), 32'hDEBB20E3);
    chk("arp_frame_done", fd_cnt - f0, 1);

    // Back-to-back frames with in_valid held through the gap.
    base = cap_q.size(); f0 = fd_cnt; g0 = gap_ready; gb = gaps_q.size();
    p = rand_payload(30);
    p2 = rand_payload(75);
    exp_q.delete();
    build_exp(p, 60, 1'b0);
    build_exp(p2, 60, 1'b0);
    queue_frame(p);
    queue_frame(p2);
    run_stream(-1, sent);
    wait_idle();
    check_stream("b2b", base);
    chk("b2b_gap", (gaps_q.size() > gb) ? gaps_q[$] : -1, 12);
    chk("b2b_ready_in_gap", gap_ready - g0, 0);
    chk("b2b_frame_done", fd_cnt - f0, 2);

    // Pad boundaries, in_last at MAX_LEN, then random frames on both framers.
    for (int k = 0; k < 10; k++) begin
      if (k < 3) begin
        sel = 1'b1; len = 59 + k;
      end else if (k == 3) begin
        sel = 1'b0; len = 64;
      end else begin
        sel = 1'($urandom_range(1));
        len = sel ? $urandom_range(100, 1) : $urandom_range(64, 1);
      end
      min_len = sel ? 60 : 0;
      base = cap_q.size(); f0 = fd_cnt; e0 = err_cnt;
      p = rand_payload(len);
      exp_q.delete();
      build_exp(p, min_len, 1'b0);
      queue_frame(p);
      run_stream(-1, sent);
      wait_idle();
      check_stream($sformatf("frame%0d_len%0d", k, len), base);
      chk($sformatf("frame%0d_done", k), fd_cnt - f0, 1);
      chk($sformatf("frame%0d_err", k), err_cnt - e0, 0);
    end

    // Underrun after 10 payload bytes.
    sel = 1'b0; base = cap_q.size(); e0 = err_cnt;
    p = rand_payload(20);
    queue_frame(p);
    run_stream(10, sent);
    wait_idle();
    chk("underrun_sent", sent, 10);
    p2.delete();
    for (int i = 0; i < 10; i++) p2.push_back(p[i]);
    exp_q.delete();
    build_exp(p2, 0, 1'b1);
    check_stream("underrun", base);
    chk("underrun_tx_err", err_cnt - e0, 1);
    chk_ne("underrun_residue", residue(base), 32'hDEBB20E3);

    // 70 bytes offered to a MAX_LEN=64 framer.
    base = cap_q.size(); e0 = err_cnt;
    p = rand_payload(70);
    queue_frame(p);
    run_stream(-1, sent);
    wait_idle();
    chk("maxlen_sent", sent, 64);
    p2.delete();
    for (int i = 0; i < 64; i++) p2.push_back(p[i]);
    exp_q.delete();
    build_exp(p2, 0, 1'b1);
    check_stream("maxlen", base);
    chk("maxlen_tx_err", err_cnt - e0, 1);

    // Reset asserted mid-payload, then a clean frame.
    sel = 1'b1;
    drv_data = 8'($urandom_range(255));
    drv_valid = 1'b1;
    g = 0;
    while (!sel_ready && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    chk("rst_reached_data", {31'd0, sel_ready}, 32'd1);
    repeat (3) @(posedge clk);
    #2 rstn = 1'b0;
    #1 chk("rst_txv_busy", {30'd0, sel_txv, sel_busy}, 32'd0);
    drv_valid = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    base = cap_q.size(); f0 = fd_cnt;
    p = rand_payload(15);
    exp_q.delete();
    build_exp(p, 60, 1'b0);
    queue_frame(p);
    run_stream(-1, sent);
    wait_idle();
    check_stream("post_reset", base);
    chk("post_reset_done", fd_cnt - f0, 1);

    chk("txd_zero_when_idle", idle_txd, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
